// File: rtl/hyperbus_ca_decode.sv
// HyperBus responder CA capture/decode, access-latency timer and data-phase word strobes.
// Define HB_CA_CHECK_EN to flag a nonzero reserved field CA[15:3] and drop the transaction.
module hyperbus_ca_decode #(
  parameter int LATENCY_CLKS = 6,
  parameter int WRAP_WORDS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        dq_valid,
  input  logic [7:0]  dq_in,
  output logic        ca_valid,
  output logic        ca_read,
  output logic        ca_reg_space,
  output logic        ca_linear,
  output logic [31:0] ca_addr,
  output logic        ca_err,
  output logic        ca_abort,
  output logic        data_phase,
  output logic        word_stb,
  output logic [31:0] word_addr,
  output logic [15:0] word_data
);
  // state  | meaning
  // IDLE   | waiting for the first CA byte
  // CA     | shifting in CA bytes 2..6
  // LAT    | initial access latency, DQ ignored
  // DATA   | pairing bytes into word strobes
  // DROP   | CA rejected, waiting for cs_n to rise
  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_DATA, S_DROP} state_t;

  localparam logic [4:0]  LAT_LOAD  = 5'(LATENCY_CLKS - 1);
  localparam logic [31:0] WRAP_MASK = 32'(WRAP_WORDS - 1);

  state_t      state, state_nx;
  logic [39:0] ca_sh, ca_sh_nx;
  logic [2:0]  byte_cnt, byte_cnt_nx;
  logic [4:0]  lat_cnt, lat_cnt_nx;
  logic        hi_have, hi_have_nx;
  logic [7:0]  hi_byte, hi_byte_nx;
  logic [31:0] cur_addr, cur_addr_nx;
  logic        ca_valid_nx, ca_read_nx, ca_reg_space_nx, ca_linear_nx, ca_err_nx;
  logic        ca_abort_nx, data_phase_nx, word_stb_nx;
  logic [31:0] ca_addr_nx, word_addr_nx;
  logic [15:0] word_data_nx;

  logic [47:0] ca_full;
  logic [31:0] addr_inc, addr_adv;
  logic        rsvd_err;

  assign ca_full  = {ca_sh, dq_in};
  assign addr_inc = cur_addr + 32'd1;
  // wrapped bursts only advance the low log2(WRAP_WORDS) bits
  assign addr_adv = ca_linear ? addr_inc : ((cur_addr & ~WRAP_MASK) | (addr_inc & WRAP_MASK));

`ifdef HB_CA_CHECK_EN
  assign rsvd_err = |ca_full[15:3];
`else
  logic rsvd_unused;
  assign rsvd_unused = |ca_full[15:3];
  assign rsvd_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ca_sh        <= '0;
      byte_cnt     <= '0;
      lat_cnt      <= '0;
      hi_have      <= 1'b0;
      hi_byte      <= '0;
      cur_addr     <= '0;
      ca_valid     <= 1'b0;
      ca_read      <= 1'b0;
      ca_reg_space <= 1'b0;
      ca_linear    <= 1'b0;
      ca_addr      <= '0;
      ca_err       <= 1'b0;
      ca_abort     <= 1'b0;
      data_phase   <= 1'b0;
      word_stb     <= 1'b0;
      word_addr    <= '0;
      word_data    <= '0;
    end else begin
      state        <= state_nx;
      ca_sh        <= ca_sh_nx;
      byte_cnt     <= byte_cnt_nx;
      lat_cnt      <= lat_cnt_nx;
      hi_have      <= hi_have_nx;
      hi_byte      <= hi_byte_nx;
      cur_addr     <= cur_addr_nx;
      ca_valid     <= ca_valid_nx;
      ca_read      <= ca_read_nx;
      ca_reg_space <= ca_reg_space_nx;
      ca_linear    <= ca_linear_nx;
      ca_addr      <= ca_addr_nx;
      ca_err       <= ca_err_nx;
      ca_abort     <= ca_abort_nx;
      data_phase   <= data_phase_nx;
      word_stb     <= word_stb_nx;
      word_addr    <= word_addr_nx;
      word_data    <= word_data_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    ca_sh_nx        = ca_sh;
    byte_cnt_nx     = byte_cnt;
    lat_cnt_nx      = lat_cnt;
    hi_have_nx      = hi_have;
    hi_byte_nx      = hi_byte;
    cur_addr_nx     = cur_addr;
    ca_valid_nx     = 1'b0;
    ca_abort_nx     = 1'b0;
    word_stb_nx     = 1'b0;
    ca_read_nx      = ca_read;
    ca_reg_space_nx = ca_reg_space;
    ca_linear_nx    = ca_linear;
    ca_addr_nx      = ca_addr;
    ca_err_nx       = ca_err;
    data_phase_nx   = data_phase;
    word_addr_nx    = word_addr;
    word_data_nx    = word_data;
    if (cs_n) begin
      state_nx      = S_IDLE;
      byte_cnt_nx   = '0;
      hi_have_nx    = 1'b0;
      data_phase_nx = 1'b0;
      ca_abort_nx   = (state == S_CA);
    end else begin
      case (state)
        S_IDLE: if (dq_valid) begin
          ca_sh_nx    = {32'd0, dq_in};
          byte_cnt_nx = 3'd1;
          state_nx    = S_CA;
        end
        S_CA: if (dq_valid) begin
          if (byte_cnt == 3'd5) begin
            ca_valid_nx     = 1'b1;
            ca_read_nx      = ca_full[47];
            ca_reg_space_nx = ca_full[46];
            ca_linear_nx    = ca_full[45];
            ca_addr_nx      = {ca_full[44:16], ca_full[2:0]};
            ca_err_nx       = rsvd_err;
            byte_cnt_nx     = '0;
            lat_cnt_nx      = LAT_LOAD;
            state_nx        = rsvd_err ? S_DROP : S_LAT;
          end else begin
            ca_sh_nx    = {ca_sh[31:0], dq_in};
            byte_cnt_nx = byte_cnt + 3'd1;
          end
        end
        S_LAT: begin
          if (lat_cnt == 5'd0) begin
            state_nx      = S_DATA;
            data_phase_nx = 1'b1;
            cur_addr_nx   = ca_addr;
            hi_have_nx    = 1'b0;
          end else begin
            lat_cnt_nx = lat_cnt - 5'd1;
          end
        end
        S_DATA: if (dq_valid) begin
          if (!hi_have) begin
            hi_byte_nx = dq_in;
            hi_have_nx = 1'b1;
          end else begin
            word_stb_nx  = 1'b1;
            word_addr_nx = cur_addr;
            word_data_nx = ca_read ? 16'd0 : {hi_byte, dq_in};
            hi_have_nx   = 1'b0;
            cur_addr_nx  = addr_adv;
          end
        end
        S_DROP: ;
        default: state_nx = S_IDLE;
      endcase
    end
  end
endmodule
